// File: rtl/inv_key_schedule_if.sv
// Request/round-key stream between a reverse AES-128 key schedule and its consumer.
interface inv_key_schedule_if;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, rk_ready,
    input  rk_out, rk_round, rk_valid, busy, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output rk_out, rk_round, rk_valid, busy, done
  );
endinterface

// File: rtl/inv_key_schedule.sv
// Walks the AES-128 key schedule backwards from the round-10 key, emitting
// round keys 9..0 one at a time under a valid/ready handshake.
module inv_key_schedule (
  input  logic              clk,
  input  logic              rst,
  inv_key_schedule_if.slave bus
);

  // Forward FIPS-197 S-box; element 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t       state, nextState;
  logic [127:0] keyReg, keyNext, stepKey;
  logic [3:0]   roundCnt, cntNext;
  logic         doneReg, doneNext;
  logic [31:0]  w0p, w1p, w2p, w3p;
  logic [31:0]  w0n, w1n, w2n, w3n;

  function automatic logic [31:0] subRot(input logic [31:0] w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Undo one forward step: recover w3..w1 by XOR-ing neighbours, then w0 from the recovered w3.
  always_comb begin
    {w0p, w1p, w2p, w3p} = keyReg;
    w3n     = w3p ^ w2p;
    w2n     = w2p ^ w1p;
    w1n     = w1p ^ w0p;
    w0n     = w0p ^ subRot(w3n) ^ {rcon(roundCnt), 24'h000000};
    stepKey = {w0n, w1n, w2n, w3n};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      keyReg   <= '0;
      roundCnt <= '0;
      doneReg  <= 1'b0;
    end else begin
      state    <= nextState;
      keyReg   <= keyNext;
      roundCnt <= cntNext;
      doneReg  <= doneNext;
    end
  end

  always_comb begin
    nextState = state;
    keyNext   = keyReg;
    cntNext   = roundCnt;
    doneNext  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          keyNext   = bus.key_in;
          cntNext   = 4'd10;
          nextState = CALC;
        end
      end
      CALC: begin
        keyNext   = stepKey;
        cntNext   = roundCnt - 4'd1;
        nextState = OUT;
      end
      OUT: begin
        if (bus.rk_ready) begin
          if (roundCnt == 4'd0) begin
            doneNext  = 1'b1;
            nextState = IDLE;
          end else begin
            nextState = CALC;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign bus.rk_out   = keyReg;
  assign bus.rk_round = roundCnt;
  assign bus.rk_valid = (state == OUT);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = doneReg;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: FIPS-197 vector table plus random keys checked
// against a forward key expansion built from GF(2^8) arithmetic.
module tb_inv_key_schedule;

  logic clk = 1'b0;
  logic rst;

  inv_key_schedule_if bus();

  inv_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int unsigned  round;
    logic [127:0] key;
  } vec_t;

  vec_t         fipsTab [11];
  logic [7:0]   sbox    [256];
  logic [127:0] expKeys [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chkN(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic chkInt(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] r = x;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expandModel(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) expKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One full reverse expansion of k10; hold = ready-low cycles per key,
  // disturbRound = round at which a foreign start/key_in is injected,
  // abortRound = round at which rst is pulsed, keepStart leaves start high.
  task automatic runSeq(input logic [127:0] k10, input int unsigned hold,
                        input int disturbRound, input int abortRound, input bit keepStart);
    int unsigned  cnt;
    logic [127:0] held;
    bus.start    = 1'b1;
    bus.key_in   = k10;
    bus.rk_ready = (hold == 0);
    step();
    if (!keepStart) bus.start = 1'b0;
    chk1("calc_valid", bus.rk_valid, 1'b0);
    chk1("calc_busy", bus.busy, 1'b1);
    chkInt("calc_round", int'(bus.rk_round), 10);
    for (int r = 9; r >= 0; r--) begin
      cnt = 0;
      while (!bus.rk_valid && cnt < 8) begin
        step();
        cnt++;
      end
      if (!bus.rk_valid) begin
        tests++;
        fails++;
        $display("FAIL valid_timeout: rk_valid=0 after %0d cycles waiting for round %0d, required 1", cnt, r);
        return;
      end
      chkInt("calc_gap", int'(cnt), 1);
      chkInt("rk_round", int'(bus.rk_round), r);
      chkN("rk_out", bus.rk_out, expKeys[r]);
      if (r == abortRound) begin
        #3 rst = 1'b1;
        #1;
        chk1("rst_valid", bus.rk_valid, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_done", bus.done, 1'b0);
        chkN("rst_key", bus.rk_out, '0);
        chkInt("rst_round", int'(bus.rk_round), 0);
        step();
        #3 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
          step();
          chk1("post_rst_valid", bus.rk_valid, 1'b0);
          chk1("post_rst_busy", bus.busy, 1'b0);
        end
        return;
      end
      if (hold > 0) begin
        bus.rk_ready = 1'b0;
        held = bus.rk_out;
        repeat (hold) begin
          step();
          chk1("hold_valid", bus.rk_valid, 1'b1);
          chkN("hold_key", bus.rk_out, held);
          chkInt("hold_round", int'(bus.rk_round), r);
        end
        bus.rk_ready = 1'b1;
      end
      if (r == disturbRound) begin
        bus.start  = 1'b1;
        bus.key_in = ~k10;
      end
      step();
      if (r == disturbRound && !keepStart) bus.start = 1'b0;
      if (r > 0) begin
        chk1("done_early", bus.done, 1'b0);
      end else begin
        chk1("done_pulse", bus.done, 1'b1);
        chk1("done_idle", bus.busy, 1'b0);
      end
    end
    if (!keepStart) begin
      step();
      chk1("done_one_cycle", bus.done, 1'b0);
      chk1("idle_after", bus.busy, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] k0;

    fipsTab[0]  = '{0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    fipsTab[1]  = '{1,  128'ha0fafe1788542cb123a339392a6c7605};
    fipsTab[2]  = '{2,  128'hf2c295f27a96b9435935807a7359f67f};
    fipsTab[3]  = '{3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    fipsTab[4]  = '{4,  128'hef44a541a8525b7fb671253bdb0bad00};
    fipsTab[5]  = '{5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    fipsTab[6]  = '{6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    fipsTab[7]  = '{7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    fipsTab[8]  = '{8,  128'head27321b58dbad2312bf5607f8d292f};
    fipsTab[9]  = '{9,  128'hac7766f319fadc2128d12941575c006e};
    fipsTab[10] = '{10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    buildSbox();

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.key_in   = '0;
    bus.rk_ready = 1'b0;
    #1;
    chk1("reset_valid", bus.rk_valid, 1'b0);
    chk1("reset_busy", bus.busy, 1'b0);
    chk1("reset_done", bus.done, 1'b0);
    chkN("reset_key", bus.rk_out, '0);
    chkInt("reset_round", int'(bus.rk_round), 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk1("idle_no_start", bus.busy, 1'b0);

    for (int i = 0; i < 11; i++) expKeys[fipsTab[i].round] = fipsTab[i].key;

    runSeq(expKeys[10], 0, -1, -1, 1'b0);   // plain FIPS vector
    runSeq(expKeys[10], 5, -1, -1, 1'b0);   // backpressure
    runSeq(expKeys[10], 0, 5, -1, 1'b0);    // start while busy
    runSeq(expKeys[10], 0, -1, 4, 1'b0);    // reset mid-run
    runSeq(expKeys[10], 0, -1, -1, 1'b0);   // recovery after reset
    runSeq(expKeys[10], 0, -1, -1, 1'b1);   // back-to-back, start held
    runSeq(expKeys[10], 0, -1, -1, 1'b0);

    for (int n = 0; n < 6; n++) begin
      k0 = {$urandom, $urandom, $urandom, $urandom};
      expandModel(k0);
      runSeq(expKeys[10], $urandom_range(0, 2), -1, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
